state_lane_collector: RTL

- Receive side of the 5-lane serial state path. Each lane delivers one bit per accepted cycle; the block shifts those bits into five parallel LANE_W-bit words.
- Once LANE_W bits have arrived, it presents the full 5-word state to the downstream permutation or datapath over a valid/ready handshake.
- Sits between the serial lane shifters and the round logic that consumes the whole state.

---
 rtl/state_lane_collector.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/state_lane_collector.sv
// Deserialises five serial lanes (MSB first) into five LANE_W-bit words and hands the
// full state downstream over valid/ready. Define STATE_LANE_COLLECTOR_DBUF_EN for a
// second word bank so collection overlaps with the output hold.
//
// Handshake: a beat moves on in_valid && in_ready at a rising edge; a state moves on
// out_valid && out_ready. Once out_valid is raised, out_words stays stable until taken.
module state_lane_collector #(
   parameter  int LANE_W = 64,
   localparam int CNT_W  = $clog2(LANE_W + 1)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   input  logic [0:4]              in_bits,
   output logic                    in_ready,
   input  logic                    flush,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [0:4][LANE_W-1:0]  out_words,
   output logic [CNT_W-1:0]        bit_cnt
);

   typedef enum logic [0:0] {
      COLLECT = 1'b0,
      HOLD    = 1'b1
   } state_e;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LANE_W - 1);

   state_e                   state_q;
   logic [CNT_W-1:0]         cnt_q;
   logic [0:4][LANE_W-1:0]   sh_q;
   logic [0:4][LANE_W-1:0]   sh_d;
   logic                     out_valid_q;
   logic                     accept;
   logic                     last_beat;

   // Every lane shifts together; the newest bit enters at the LSB.
   always_comb begin
      sh_d = sh_q;
      for (int k = 0; k < 5; k++) begin
         sh_d[k] = {sh_q[k][LANE_W-2:0], in_bits[k]};
      end
   end

   assign last_beat = (cnt_q == LAST_CNT);
   assign accept    = in_valid && in_ready;
   assign out_valid = out_valid_q;
   assign bit_cnt   = cnt_q;

`ifdef STATE_LANE_COLLECTOR_DBUF_EN

   logic [0:4][LANE_W-1:0]   ob_q;
   logic                     complete;
   logic                     handshake;

   // Stall only the completing beat, and only while the output bank is still owed.
   assign in_ready  = !(out_valid_q && !out_ready && last_beat);
   assign complete  = accept && !flush && last_beat;
   assign handshake = out_valid_q && out_ready;
   assign out_words = ob_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= COLLECT;
         cnt_q       <= '0;
         sh_q        <= '0;
         ob_q        <= '0;
         out_valid_q <= 1'b0;
      end else begin
         // flush only touches the shift bank; a finished state in ob_q survives it.
         if (flush) begin
            cnt_q <= '0;
            sh_q  <= '0;
         end else if (accept) begin
            sh_q  <= sh_d;
            cnt_q <= last_beat ? '0 : cnt_q + CNT_W'(1);
         end

         if (complete) begin
            ob_q        <= sh_d;
            out_valid_q <= 1'b1;
            state_q     <= HOLD;
         end else if (handshake) begin
            out_valid_q <= 1'b0;
            state_q     <= COLLECT;
         end
      end
   end

`else

   logic in_ready_q;

   assign in_ready  = in_ready_q;
   assign out_words = sh_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= COLLECT;
         cnt_q       <= '0;
         sh_q        <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         case (state_q)
            COLLECT: begin
               // flush beats a simultaneous beat; that beat is dropped.
               if (flush) begin
                  cnt_q <= '0;
                  sh_q  <= '0;
               end else if (in_valid) begin
                  sh_q <= sh_d;
                  if (last_beat) begin
                     cnt_q       <= '0;
                     state_q     <= HOLD;
                     out_valid_q <= 1'b1;
                     in_ready_q  <= 1'b0;
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state_q     <= COLLECT;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: begin
               state_q     <= COLLECT;
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
            end
         endcase
      end
   end

`endif

endmodule
